// File: rtl/rf_write_scheduler_if.sv
// Signal bundle between the scheduler and its neighbours: WB stage, MDU,
// decode and the register file write port.
interface rf_write_scheduler_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        fwd1_valid;
  logic [31:0] fwd1_data;
  logic        fwd2_valid;
  logic [31:0] fwd2_data;

  modport master (
    output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           issue_valid, issue_rd, rs1, rs2,
    input  mdu_ready, stall, rf_write, rf_addr, rf_data,
           fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           issue_valid, issue_rd, rs1, rs2,
    output mdu_ready, stall, rf_write, rf_addr, rf_data,
           fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Shares the RF write port between WB (priority) and a 2-entry MDU result FIFO,
// and tracks MDU-pending registers for decode stall. Optional RFSCHED_FWD_EN forwards from the FIFO.
module rf_write_scheduler (
  input  logic clk,
  input  logic rst,
  rf_write_scheduler_if.slave bus
);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mdu_res_t;

  mdu_res_t [1:0] fifo_q, fifo_d;
  logic [1:0]     count_q, count_d;
  logic [31:0]    pend_q, pend_d;   // bit 0 held at zero so x0 never pends

  logic wb_grant, pop, push, mdu_ready, stall, widx;
  logic fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;

  always_comb begin
    mdu_ready = !rst && (count_q != 2'd2);
    wb_grant  = bus.wb_valid && (bus.wb_rd != 5'd0);
    pop       = !rst && !wb_grant && (count_q != 2'd0);
    push      = bus.mdu_valid && mdu_ready;

`ifdef RFSCHED_FWD_EN
    // Entry 1 is younger than entry 0 whenever both are occupied.
    fwd1_valid = 1'b0;
    fwd1_data  = '0;
    fwd2_valid = 1'b0;
    fwd2_data  = '0;
    if (!rst && bus.rs1 != 5'd0 && pend_q[bus.rs1]) begin
      if (count_q == 2'd2 && fifo_q[1].rd == bus.rs1) begin
        fwd1_valid = 1'b1;
        fwd1_data  = fifo_q[1].data;
      end else if (count_q != 2'd0 && fifo_q[0].rd == bus.rs1) begin
        fwd1_valid = 1'b1;
        fwd1_data  = fifo_q[0].data;
      end
    end
    if (!rst && bus.rs2 != 5'd0 && pend_q[bus.rs2]) begin
      if (count_q == 2'd2 && fifo_q[1].rd == bus.rs2) begin
        fwd2_valid = 1'b1;
        fwd2_data  = fifo_q[1].data;
      end else if (count_q != 2'd0 && fifo_q[0].rd == bus.rs2) begin
        fwd2_valid = 1'b1;
        fwd2_data  = fifo_q[0].data;
      end
    end
`else
    fwd1_valid = 1'b0;
    fwd1_data  = '0;
    fwd2_valid = 1'b0;
    fwd2_data  = '0;
`endif

    stall = !rst && (
              (bus.rs1 != 5'd0 && pend_q[bus.rs1] && !fwd1_valid) ||
              (bus.rs2 != 5'd0 && pend_q[bus.rs2] && !fwd2_valid) ||
              (bus.issue_valid && bus.issue_rd != 5'd0 && pend_q[bus.issue_rd]) ||
              (count_q == 2'd2));

    // Head is always entry 0; a pop shifts entry 1 down before the push lands.
    fifo_d  = fifo_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    widx    = (count_q == 2'd1) && !pop;
    if (pop)
      fifo_d[0] = fifo_q[1];
    if (push)
      fifo_d[widx] = '{rd: bus.mdu_rd, data: bus.mdu_data};

    pend_d = pend_q;
    if (pop)
      pend_d[fifo_q[0].rd] = 1'b0;
    if (bus.issue_valid && !stall && bus.issue_rd != 5'd0)
      pend_d[bus.issue_rd] = 1'b1;
    pend_d[0] = 1'b0;

    bus.rf_write = 1'b0;
    bus.rf_addr  = '0;
    bus.rf_data  = '0;
    if (!rst && wb_grant) begin
      bus.rf_write = 1'b1;
      bus.rf_addr  = bus.wb_rd;
      bus.rf_data  = bus.wb_data;
    end else if (pop) begin
      bus.rf_write = 1'b1;
      bus.rf_addr  = fifo_q[0].rd;
      bus.rf_data  = fifo_q[0].data;
    end

    bus.mdu_ready  = mdu_ready;
    bus.stall      = stall;
    bus.fwd1_valid = fwd1_valid;
    bus.fwd1_data  = fwd1_data;
    bus.fwd2_valid = fwd2_valid;
    bus.fwd2_data  = fwd2_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Shares the register file's single write port between the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a 2-entry FIFO and written only in cycles the pipeline leaves the port idle. A scoreboard of registers awaiting MDU results generates the decode-stage stall. The block sits between the WB stage, the MDU, decode, and the register file write port (write, address, data).

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  writeback stage has a result this cycle.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  buffer can accept an MDU result.
- mdu_rd  in  5  MDU result destination.
- mdu_data  in  32  MDU result value.
- issue_valid  in  1  decode issues an MDU op this cycle.
- issue_rd  in  5  destination of the issued MDU op.
- rs1  in  5  decode read address 1.
- rs2  in  5  decode read address 2.
- stall  out  1  decode must hold.
- rf_write  out  1  register file write enable.
- rf_addr  out  5  register file write address.
- rf_data  out  32  register file write data.
- fwd1_valid  out  1  rs1 value supplied by fwd1_data.
- fwd1_data  out  32  forwarded rs1 value.
- fwd2_valid  out  1  rs2 value supplied by fwd2_data.
- fwd2_data  out  32  forwarded rs2 value.

## Operation
- **FIFO:** 2 entries of {rd, data}, plus a count of 0..2.
  - mdu_ready = (count < 2) && !rst, computed from registered count only. No same-cycle pop credit.
  - Push on mdu_valid && mdu_ready.
- **Write port arbitration (combinational, same cycle):**
  - wb_valid && wb_rd != 0 → WB always granted. rf_write=1, rf_addr=wb_rd, rf_data=wb_data.
  - Else, if count > 0 → pop the head. rf_write=1, rf_addr=head.rd, rf_data=head.data.
  - Else rf_write=0, rf_addr=0, rf_data=0.
  - WB to x0 counts as idle, so the FIFO may use the port.
  - An MDU result with rd=0 is accepted, popped as a write to x0 (harmless), and clears nothing.
- **Scoreboard:** 31-bit pending vector for x1..x31.
  - Set pending[issue_rd] on issue_valid && !stall && issue_rd != 0.
  - Clear pending[rd] when a FIFO pop writes rd.
  - Set and clear of the same register in one cycle: set wins.
- **stall** = any of:
  - rs1 != 0 and pending[rs1] and not forwarded;
  - rs2 != 0 and pending[rs2] and not forwarded;
  - issue_valid && issue_rd != 0 && pending[issue_rd] (WAW);
  - count == 2 (forces a pipeline bubble so the FIFO can drain).
- issue_valid must not depend combinationally on stall.
- WB writes to a pending register are not checked; decode stall prevents them.

## Timing
- **Reset (rst=1 at posedge):** FIFO emptied, count=0, pending cleared.
- **While rst=1:** rf_write=0, rf_addr=0, rf_data=0, mdu_ready=0, stall=0, fwd*_valid=0, fwd*_data=0.
- **Reset mid-operation:** buffered MDU results are discarded and pending bits dropped; the MDU is reset alongside.
- **Latency:** result accepted at edge N → earliest RF write in cycle N+1. Each WB-occupied cycle delays it by one.
- The register file samples on the falling edge of the same cycle the write is presented.
- **Full FIFO:** mdu_ready=0 and stall=1 until a pop; mdu_ready rises the cycle after the pop.
- **Push and pop in the same cycle (count 1):** count stays 1 and order is preserved.

## Configuration
- RFSCHED_FWD_EN **defined:**
  - A pending rs1/rs2 whose result already sits in the FIFO is forwarded instead of stalling. fwdN_valid=1 and fwdN_data = the youngest matching FIFO entry.
  - A result still inside the MDU still stalls.
- RFSCHED_FWD_EN **undefined:**
  - fwd*_valid=0 and fwd*_data=0 permanently.
  - Any pending operand stalls until its FIFO entry is written.

## Test plan
- **Reset:** hold rst 2 cycles while mdu_valid=1 → no push, rf_write=0, stall=0, mdu_ready=0; mdu_ready=1 the first cycle after release.
- **Issue/stall/clear:** issue rd=5 → pending; rs1=5 → stall=1. MDU returns {5, 0xDEADBEEF} with wb_valid=0 → next cycle rf_write=1, rf_addr=5, rf_data=0xDEADBEEF; stall drops the following cycle.
- **WB priority:** two MDU results buffered, wb_valid=1 (rd=3) for 3 cycles → rf_addr=3 each cycle, count=2, mdu_ready=0, stall=1; then both entries drain in order on consecutive idle cycles.
- **WAW:** issue rd=7 while pending[7] → stall=1 and no second set. WB to x0 with count=1 → FIFO entry written that cycle.
- **Forwarding:** with RFSCHED_FWD_EN, {9, 0x1234} buffered behind WB traffic, rs2=9 → stall=0, fwd2_valid=1, fwd2_data=0x1234. Without the macro → stall=1 and fwd2_valid=0.
- **Mid-operation reset:** assert rst with count=2 and pending[4]=1 → after the edge, count=0, pending clear, and no RF write of the buffered data.
